// File: rtl/fu_dispatch_queue.sv
// In-order dispatch queue between the decoder and the FU reservation stations.
// Optional per-class dispatch counters are enabled with the DISPATCH_STATS_EN macro.
module fu_dispatch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    input  logic [2:0]       in_fu_class,
    output logic             in_ready,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic             alu_valid,
    output logic             mult_valid,
    output logic             mem_valid,
    output logic             br_valid,
    input  logic             alu_ready,
    input  logic             mult_ready,
    input  logic             mem_ready,
    input  logic             br_ready,
    output logic             illegal_drop,
    output logic [CNT_W-1:0] count
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]      stat_alu,
    output logic [31:0]      stat_mult,
    output logic [31:0]      stat_mem,
    output logic [31:0]      stat_br,
    output logic [31:0]      stat_illegal
`endif
);

    localparam logic [2:0] CLS_ALU  = 3'b000;
    localparam logic [2:0] CLS_MULT = 3'b001;
    localparam logic [2:0] CLS_MEM  = 3'b011;
    localparam logic [2:0] CLS_BR   = 3'b100;

    logic [31:0]      inst_mem  [DEPTH];
    logic [31:0]      pc_mem    [DEPTH];
    logic [2:0]       class_mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic [2:0] head_class;
    logic       head_legal;
    logic       active;
    logic       enq;
    logic       deq;
    logic       alu_fire;
    logic       mult_fire;
    logic       mem_fire;
    logic       br_fire;

    assign in_ready = (count != CNT_W'(DEPTH));

    // Head presentation: flush masks every valid so nothing leaves during a squash.
    always_comb begin
        head_class = class_mem[head];
        out_inst   = inst_mem[head];
        out_pc     = pc_mem[head];
        active     = (count != '0) && !flush;
        head_legal = 1'b0;
        case (head_class)
            CLS_ALU, CLS_MULT, CLS_MEM, CLS_BR: head_legal = 1'b1;
            default:                            head_legal = 1'b0;
        endcase
        alu_valid    = active && (head_class == CLS_ALU);
        mult_valid   = active && (head_class == CLS_MULT);
        mem_valid    = active && (head_class == CLS_MEM);
        br_valid     = active && (head_class == CLS_BR);
        illegal_drop = active && !head_legal;
        alu_fire     = alu_valid  && alu_ready;
        mult_fire    = mult_valid && mult_ready;
        mem_fire     = mem_valid  && mem_ready;
        br_fire      = br_valid   && br_ready;
        deq          = alu_fire || mult_fire || mem_fire || br_fire || illegal_drop;
        enq          = in_valid && in_ready && !flush;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i]  <= '0;
                pc_mem[i]    <= '0;
                class_mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                inst_mem[tail]  <= in_inst;
                pc_mem[tail]    <= in_pc;
                class_mem[tail] <= in_fu_class;
                tail            <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(deq);
        end
    end

`ifdef DISPATCH_STATS_EN
    // Statistics survive a flush; only reset clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_alu     <= '0;
            stat_mult    <= '0;
            stat_mem     <= '0;
            stat_br      <= '0;
            stat_illegal <= '0;
        end else begin
            if (alu_fire)     stat_alu     <= stat_alu + 32'd1;
            if (mult_fire)    stat_mult    <= stat_mult + 32'd1;
            if (mem_fire)     stat_mem     <= stat_mem + 32'd1;
            if (br_fire)      stat_br      <= stat_br + 32'd1;
            if (illegal_drop) stat_illegal <= stat_illegal + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fu_dispatch_queue.md
Name: fu_dispatch_queue

Overview:
- In-order buffer between the instruction decoder and the functional-unit reservation stations.
- Accepts decoded instructions (raw inst, PC, 3-bit FU class from the decoder) with a valid/ready handshake.
- Holds them in a circular FIFO and presents the head entry to exactly one FU-class port: ALU, MULT, MEM or BRANCH.
- Dispatch is strictly in order; a stalled head blocks all younger entries.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), head/tail pointer width (derived).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- flush  input  1  synchronous squash of all buffered entries (branch mispredict).
- in_valid  input  1  decoder presents an instruction.
- in_inst  input  32  raw instruction word.
- in_pc  input  32  instruction PC.
- in_fu_class  input  3  decoder class code: 3'b000 ALU, 3'b001 MULT, 3'b011 MEM, 3'b100 BRANCH/CSR/system; all other codes are illegal.
- in_ready  output  1  queue can accept this cycle.
- out_inst  output  32  head entry instruction (shared by all FU ports).
- out_pc  output  32  head entry PC.
- alu_valid / mult_valid / mem_valid / br_valid  output  1 each  head entry targets that FU class.
- alu_ready / mult_ready / mem_ready / br_ready  input  1 each  target reservation station can accept.
- illegal_drop  output  1  pulse: head held an illegal class code and was discarded this cycle.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset state (reset high at an edge):
  - head=0, tail=0, count=0.
  - All four *_valid=0, illegal_drop=0, in_ready=1 from the following cycle.
  - Reset overrides flush and any handshake in the same cycle.
  - Reset mid-transfer discards all entries; no partial dispatch.
- Enqueue:
  - in_ready = (count != DEPTH); combinational from count, no dependence on same-cycle dequeue.
  - When full, no enqueue even if a dequeue occurs the same cycle.
  - On in_valid && in_ready: write {inst, pc, class} at tail; tail wraps from DEPTH-1 to 0.
- Latency: an entry enqueued at edge N is visible at the head no earlier than cycle N+1; there is no bypass path.
- Head presentation (combinational from head entry):
  - When count==0, all *_valid=0; out_inst/out_pc are don't-care but must not be X-propagating (drive the stored value).
  - When count>0, exactly one *_valid is asserted, selected by the head class code.
- Dequeue:
  - A legal head dequeues on the edge where its selected X_valid && X_ready.
  - Ready inputs of non-selected ports are ignored.
  - head increments and wraps like tail.
- Illegal class at head:
  - No *_valid asserted.
  - illegal_drop=1 for that cycle; the entry is dequeued at the next edge unconditionally.
- Simultaneous enqueue and dequeue (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Flush:
  - While flush is high, all *_valid=0 and illegal_drop=0.
  - At the edge, head=tail=0 and count=0.
  - A same-cycle enqueue is discarded.
  - in_ready stays per its normal rule during the flush cycle.
- Count update: count_next = count + enq - deq; it can never exceed DEPTH or underflow.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- When defined:
  - Adds 32-bit output ports stat_alu, stat_mult, stat_mem, stat_br, stat_illegal.
  - Each increments by 1 on every completed dispatch (or illegal drop) of that class.
  - Counters cleared by reset only, not by flush; they wrap from 2^32-1 to 0.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then enqueue class 000 inst 32'h00500093 pc 32'h0 with alu_ready=1:
  - alu_valid rises the cycle after enqueue.
  - out_inst=32'h00500093; dequeued on that edge; count returns to 0.
- Enqueue MULT then ALU with mult_ready=0, alu_ready=1:
  - mult_valid held and alu_valid=0 for 5 cycles, count=2.
  - Raise mult_ready: MULT dispatches, then ALU on the next cycle (in order).
- Fill 8 entries with all readies=0:
  - in_ready=0 at count=8.
  - Assert br_ready with a BRANCH head and in_valid=1: dequeue only, count=7; in_ready=1 next cycle.
  - Push 20 more entries through; confirm pointer wrap and data order.
- Enqueue class 3'b010 followed by MEM:
  - illegal_drop pulses 1 cycle with no valid asserted.
  - mem_valid on the following cycle.
- With 5 entries queued, assert flush together with in_valid:
  - All valids 0 that cycle; count=0 next cycle; the flush-cycle instruction is never dispatched.
- With DISPATCH_STATS_EN: dispatch 3 ALU, 2 MEM, 1 illegal.
  - stat_alu=3, stat_mem=2, stat_illegal=1.
  - Counts unchanged after a flush; all zero after reset.
